// File: rtl/poker_pkg.sv
// poker_pkg: constants shared by the transmit framer and the card receiver.
//   - frame header / type bytes
//   - internal <-> wire rank aliases for the two ranks that are re-encoded
//   - play_cnt codes
//   - framer FSM state encoding and frame lengths
package poker_pkg;

  // Frame header and type bytes
  localparam logic [7:0] HDR_PLAY    = 8'hF2;
  localparam logic [7:0] HDR_PASS    = 8'hF0;
  localparam logic [7:0] TYPE_SINGLE = 8'h01;
  localparam logic [7:0] TYPE_PAIR   = 8'h02;
  localparam logic [7:0] PASS_PAD    = 8'h00;

  // Rank nibbles that differ between the game logic and the wire
  localparam logic [3:0] RANK_2_INT  = 4'hF;
  localparam logic [3:0] RANK_A_INT  = 4'hE;
  localparam logic [3:0] RANK_2_WIRE = 4'h2;
  localparam logic [3:0] RANK_A_WIRE = 4'h1;

  // play_cnt codes
  localparam logic [1:0] PLAY_PASS    = 2'd0;
  localparam logic [1:0] PLAY_SINGLE  = 2'd1;
  localparam logic [1:0] PLAY_PAIR    = 2'd2;
  localparam logic [1:0] PLAY_ILLEGAL = 2'd3;

  // Frame geometry
  localparam int         FRAME_MAX  = 5;
  localparam logic [2:0] LEN_PASS   = 3'd3;
  localparam logic [2:0] LEN_SINGLE = 3'd4;
  localparam logic [2:0] LEN_PAIR   = 3'd5;

  // Framer FSM state encoding
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_GAP   = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

endpackage

// File: rtl/poker_card_encode.sv
// poker_card_encode: combinational internal-to-wire card byte converter.
//   card_int  in  8  card in internal rank encoding (rank nibble, suit nibble)
//   card_wire out 8  same card in wire encoding
// Only the rank nibble is remapped (F->2, E->1); the suit nibble passes through.
module poker_card_encode
  import poker_pkg::*;
(
  input  logic [7:0] card_int,
  output logic [7:0] card_wire
);

  always_comb begin
    card_wire = card_int;
    if (card_int[7:4] == RANK_2_INT) begin
      card_wire[7:4] = RANK_2_WIRE;
    end else if (card_int[7:4] == RANK_A_INT) begin
      card_wire[7:4] = RANK_A_WIRE;
    end
  end

endmodule

// File: rtl/poker_frame_tx.sv
// poker_frame_tx: transmit framer for the card-game serial link.
// Turns a play decision into a 3/4/5-byte frame and feeds it to a UART TX core
// one byte at a time, with an idle gap between bytes and a per-byte timeout.
//   sys_clk        in   1  system clock
//   sys_rst        in   1  synchronous active-high reset
//   play_req       in   1  request to send a play (taken only while play_ready)
//   play_cnt       in   2  0=pass 1=single 2=pair 3=illegal
//   play_cards     in  16  internal cards; single=[7:0], pair=[15:8] then [7:0]
//   play_ready     out  1  framer idle
//   tx_data        out  8  byte for the UART, held from tx_start to finish
//   tx_start       out  1  one-cycle launch pulse
//   txd_finish_pos in   1  UART byte-complete pulse
//   send_done      out  1  frame fully sent
//   send_err       out  1  illegal play_cnt or UART timeout
module poker_frame_tx
  import poker_pkg::*;
#(
  parameter int GAP_CYCLES = 16,
  parameter int TX_TIMEOUT = 2_000_000
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        play_req,
  input  logic [1:0]  play_cnt,
  input  logic [15:0] play_cards,
  output logic        play_ready,
  output logic [7:0]  tx_data,
  output logic        tx_start,
  input  logic        txd_finish_pos,
  output logic        send_done,
  output logic        send_err
);

  localparam int TW = $clog2(TX_TIMEOUT + 1);
  localparam int GW = $clog2(GAP_CYCLES + 1);

  logic [2:0]    state_reg, state_next;
  logic [2:0]    idx_reg, idx_next;
  logic [2:0]    len_reg, len_next;
  logic [7:0]    frame_reg [FRAME_MAX];
  logic [7:0]    frame_next [FRAME_MAX];
  logic [TW-1:0] tmo_cnt_reg, tmo_cnt_next;
  logic [GW-1:0] gap_cnt_reg, gap_cnt_next;
  logic [7:0]    tx_data_reg, tx_data_next;
  logic          tx_start_reg, tx_start_next;
  logic          send_done_reg, send_done_next;
  logic          send_err_reg, send_err_next;

  // Lane 0 carries play_cards[7:0], lane 1 carries play_cards[15:8].
  logic [7:0] lane_wire [2];
  logic [7:0] load_frame [FRAME_MAX];
  logic [2:0] load_len;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_lane
      poker_card_encode u_enc (
        .card_int  (play_cards[gi*8 +: 8]),
        .card_wire (lane_wire[gi])
      );
    end
  endgenerate

  // Frame image for the current request; only captured in the accept cycle,
  // so later changes on play_cards/play_cnt cannot reach a frame in flight.
  always_comb begin
    for (int i = 0; i < FRAME_MAX; i++) begin
      load_frame[i] = 8'h00;
    end
    load_len = LEN_PASS;
    case (play_cnt)
      PLAY_SINGLE: begin
        load_frame[0] = HDR_PLAY;
        load_frame[1] = TYPE_SINGLE;
        load_frame[2] = TYPE_SINGLE;
        load_frame[3] = lane_wire[0];
        load_len      = LEN_SINGLE;
      end
      PLAY_PAIR: begin
        load_frame[0] = HDR_PLAY;
        load_frame[1] = TYPE_PAIR;
        load_frame[2] = TYPE_PAIR;
        load_frame[3] = lane_wire[1];
        load_frame[4] = lane_wire[0];
        load_len      = LEN_PAIR;
      end
      default: begin
        load_frame[0] = HDR_PASS;
        load_frame[1] = HDR_PASS;
        load_frame[2] = PASS_PAD;
        load_len      = LEN_PASS;
      end
    endcase
  end

  always_comb begin
    state_next     = state_reg;
    idx_next       = idx_reg;
    len_next       = len_reg;
    frame_next     = frame_reg;
    tmo_cnt_next   = tmo_cnt_reg;
    gap_cnt_next   = gap_cnt_reg;
    tx_data_next   = tx_data_reg;
    tx_start_next  = 1'b0;
    send_done_next = 1'b0;
    send_err_next  = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (play_req) begin
          if (play_cnt == PLAY_ILLEGAL) begin
            send_err_next = 1'b1;
          end else begin
            frame_next = load_frame;
            len_next   = load_len;
            idx_next   = 3'd0;
            state_next = ST_START;
          end
        end
      end

      ST_START: begin
        // tx_data and tx_start are registered here so they leave the block
        // together and tx_data is already stable when the UART sees the pulse.
        tx_data_next  = frame_reg[idx_reg];
        tx_start_next = 1'b1;
        tmo_cnt_next  = '0;
        state_next    = ST_WAIT;
      end

      ST_WAIT: begin
        // Finish is tested first so it wins over a simultaneous timeout.
        if (txd_finish_pos) begin
          if (idx_reg == len_reg - 3'd1) begin
            send_done_next = 1'b1;
            state_next     = ST_DONE;
          end else begin
            idx_next     = idx_reg + 3'd1;
            gap_cnt_next = '0;
            state_next   = ST_GAP;
          end
        end else if (tmo_cnt_reg == TW'(TX_TIMEOUT - 1)) begin
          send_err_next = 1'b1;
          state_next    = ST_IDLE;
        end else begin
          tmo_cnt_next = tmo_cnt_reg + 1'b1;
        end
      end

      ST_GAP: begin
        if (gap_cnt_reg == GW'(GAP_CYCLES - 1)) begin
          state_next = ST_START;
        end else begin
          gap_cnt_next = gap_cnt_reg + 1'b1;
        end
      end

      ST_DONE: begin
        // send_done was raised on entry; this cycle just returns to IDLE.
        state_next = ST_IDLE;
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_reg     <= ST_IDLE;
      idx_reg       <= 3'd0;
      len_reg       <= 3'd0;
      for (int i = 0; i < FRAME_MAX; i++) begin
        frame_reg[i] <= 8'h00;
      end
      tmo_cnt_reg   <= '0;
      gap_cnt_reg   <= '0;
      tx_data_reg   <= 8'h00;
      tx_start_reg  <= 1'b0;
      send_done_reg <= 1'b0;
      send_err_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      idx_reg       <= idx_next;
      len_reg       <= len_next;
      frame_reg     <= frame_next;
      tmo_cnt_reg   <= tmo_cnt_next;
      gap_cnt_reg   <= gap_cnt_next;
      tx_data_reg   <= tx_data_next;
      tx_start_reg  <= tx_start_next;
      send_done_reg <= send_done_next;
      send_err_reg  <= send_err_next;
    end
  end

  assign play_ready = (state_reg == ST_IDLE);
  assign tx_data    = tx_data_reg;
  assign tx_start   = tx_start_reg;
  assign send_done  = send_done_reg;
  assign send_err   = send_err_reg;

endmodule

// File: tb/tb_poker_frame_tx.sv
// Self-checking bench for poker_frame_tx. A cycle-indexed event model predicts
// when tx_start/send_done/send_err pulse, which byte must be on tx_data, and
// when play_ready is low; one negedge process compares the DUT every cycle.
// Directed frames are additionally pinned with literal byte/latency values.
module tb_poker_frame_tx;

  localparam int GAP  = 3;
  localparam int TMO  = 100;
  localparam int MAXC = 8192;

  typedef logic [7:0] byte_q_t[$];

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        play_req = 1'b0;
  logic [1:0]  play_cnt = 2'd0;
  logic [15:0] play_cards = 16'h0000;
  logic        txd_finish_pos = 1'b0;
  logic        play_ready, tx_start, send_done, send_err;
  logic [7:0]  tx_data;

  always #5 sys_clk = ~sys_clk;

  poker_frame_tx #(.GAP_CYCLES(GAP), .TX_TIMEOUT(TMO)) dut (
    .sys_clk        (sys_clk),
    .sys_rst        (sys_rst),
    .play_req       (play_req),
    .play_cnt       (play_cnt),
    .play_cards     (play_cards),
    .play_ready     (play_ready),
    .tx_data        (tx_data),
    .tx_start       (tx_start),
    .txd_finish_pos (txd_finish_pos),
    .send_done      (send_done),
    .send_err       (send_err)
  );

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // ---------------- behavioural reference ----------------
  function automatic logic [7:0] to_wire(input logic [7:0] c);
    logic [3:0] r;
    r = c[7:4];
    if (r == 4'hF) r = 4'h2;
    else if (r == 4'hE) r = 4'h1;
    return {r, c[3:0]};
  endfunction

  function automatic logic [7:0] to_int(input logic [7:0] w);
    logic [3:0] r;
    r = w[7:4];
    if (r == 4'h2) r = 4'hF;
    else if (r == 4'h1) r = 4'hE;
    return {r, w[3:0]};
  endfunction

  function automatic byte_q_t build_frame(input logic [1:0] cnt, input logic [15:0] cards);
    byte_q_t q;
    if (cnt == 2'd0) q = '{8'hF0, 8'hF0, 8'h00};
    else if (cnt == 2'd1) q = '{8'hF2, 8'h01, 8'h01, to_wire(cards[7:0])};
    else q = '{8'hF2, 8'h02, 8'h02, to_wire(cards[15:8]), to_wire(cards[7:0])};
    return q;
  endfunction

  // Expected outputs, indexed by cycle number.
  bit         exp_start [MAXC];
  bit         exp_done  [MAXC];
  bit         exp_err   [MAXC];
  bit         exp_busy  [MAXC];
  bit         exp_dv    [MAXC];
  logic [7:0] exp_data  [MAXC];

  bit      m_active  = 1'b0;
  bit      m_wait    = 1'b0;
  int      m_ts      = 0;
  int      m_release = -1;
  int      m_idx     = 0;
  byte_q_t m_frame;

  task automatic schedule(input int t);
    exp_start[t] = 1'b1;
    m_ts   = t;
    m_wait = 1'b1;
  endtask

  // Consume the inputs of cycle n; only cycles > n are ever written.
  task automatic model_step(input int n, input logic rst, input logic req,
                            input logic [1:0] cnt, input logic [15:0] cards, input logic fin);
    if (n + GAP + 4 >= MAXC) return;
    if (rst) begin
      m_active = 1'b0; m_wait = 1'b0; m_release = -1;
      for (int k = n + 1; k <= n + GAP + 3; k++) begin
        exp_start[k] = 1'b0; exp_done[k] = 1'b0; exp_err[k] = 1'b0;
        exp_busy[k] = 1'b0; exp_dv[k] = 1'b0;
      end
      exp_dv[n+1] = 1'b1; exp_data[n+1] = 8'h00;
      return;
    end
    if (m_active && n == m_release) m_active = 1'b0;
    if (!m_active) begin
      if (req) begin
        if (cnt == 2'd3) exp_err[n+1] = 1'b1;
        else begin
          m_frame = build_frame(cnt, cards);
          m_active = 1'b1; m_release = -1; m_idx = 0;
          schedule(n + 2);
        end
      end
    end else if (m_wait && n >= m_ts) begin
      if (fin) begin
        m_wait = 1'b0;
        if (m_idx == m_frame.size() - 1) begin
          exp_done[n+1] = 1'b1;
          m_release = n + 2;
        end else begin
          m_idx++;
          schedule(n + GAP + 2);
        end
      end else if (n == m_ts + TMO - 1) begin
        m_wait = 1'b0;
        exp_err[n+1] = 1'b1;
        m_release = n + 1;
      end
    end
    exp_busy[n+1] = m_active && (m_release != n + 1);
    if (m_wait && m_ts <= n + 1) begin
      exp_dv[n+1] = 1'b1;
      exp_data[n+1] = m_frame[m_idx];
    end
  endtask

  // ---------------- per-cycle compare ----------------
  bit chk_en = 1'b0;
  always @(negedge sys_clk) begin
    if (chk_en && cyc < MAXC) begin
      check("tx_start", 32'(tx_start), 32'(exp_start[cyc]));
      check("send_done", 32'(send_done), 32'(exp_done[cyc]));
      check("send_err", 32'(send_err), 32'(exp_err[cyc]));
      check("play_ready", 32'(play_ready), 32'(!exp_busy[cyc]));
      if (exp_dv[cyc]) check("tx_data", 32'(tx_data), 32'(exp_data[cyc]));
    end
  end

  // ---------------- stimulus / UART responder ----------------
  int         fin_due   = -1;
  bit         uart_mute = 1'b0;
  logic [7:0] rx_log[$];
  int         start_log[$];
  int         fin_log[$];
  int         done_cyc = -1;
  int         err_cyc  = -1;

  task automatic run_cycle(input logic rst, input logic req, input logic [1:0] cnt, input logic [15:0] cards);
    if (tx_start) begin
      rx_log.push_back(tx_data);
      start_log.push_back(cyc);
      if (!uart_mute) fin_due = cyc + int'($urandom_range(1, 8));
    end
    if (send_done) done_cyc = cyc;
    if (send_err)  err_cyc = cyc;
    txd_finish_pos = (fin_due == cyc);
    if (txd_finish_pos) begin
      fin_log.push_back(cyc);
      fin_due = -1;
    end
    if (rst) fin_due = -1;
    sys_rst = rst; play_req = req; play_cnt = cnt; play_cards = cards;
    model_step(cyc, rst, req, cnt, cards, txd_finish_pos);
    @(negedge sys_clk);
  endtask

  task automatic idle(input int k);
    repeat (k) run_cycle(1'b0, 1'b0, 2'($urandom), 16'($urandom));
  endtask

  task automatic clear_logs();
    rx_log.delete(); start_log.delete(); fin_log.delete();
    done_cyc = -1; err_cyc = -1;
  endtask

  // Issue one play and run until send_done/send_err (bounded). poke_off>0 adds
  // a second request that many cycles after the accepted one.
  task automatic send_play(input logic [1:0] cnt, input logic [15:0] cards,
                           input int poke_off, output int acc);
    clear_logs();
    acc = cyc;
    run_cycle(1'b0, 1'b1, cnt, cards);
    for (int i = 0; i < 400 && done_cyc < 0 && err_cyc < 0; i++) begin
      run_cycle(1'b0, (poke_off > 0) && (cyc - acc == poke_off), 2'd1, 16'h00E5);
    end
    if (done_cyc < 0 && err_cyc < 0) check("frame_end_seen", 32'd0, 32'd1);
  endtask

  task automatic check_bytes(input string name, input byte_q_t want);
    check({name, "_len"}, 32'(rx_log.size()), 32'(want.size()));
    for (int i = 0; i < want.size() && i < rx_log.size(); i++)
      check($sformatf("%s_b%0d", name, i), 32'(rx_log[i]), 32'(want[i]));
  endtask

  initial begin
    int acc;
    @(negedge sys_clk);
    repeat (3) run_cycle(1'b1, 1'b0, 2'd0, 16'h0000);
    chk_en = 1'b1;
    check("reset_ready", 32'(play_ready), 32'd1);
    check("reset_tx_start", 32'(tx_start), 32'd0);
    check("reset_tx_data", 32'(tx_data), 32'h00);
    idle(2);

    // Pass frame
    send_play(2'd0, 16'($urandom), 0, acc);
    check_bytes("pass", '{8'hF0, 8'hF0, 8'h00});
    if (start_log.size() > 0) check("first_start_lat", 32'(start_log[0] - acc), 32'd2);
    if (fin_log.size() > 0) check("done_lat", 32'(done_cyc - fin_log[fin_log.size()-1]), 32'd1);
    run_cycle(1'b0, 1'b0, 2'd0, 16'h0000);
    check("ready_after_done", 32'(play_ready), 32'd1);

    // Singles with and without rank conversion
    send_play(2'd1, {8'($urandom), 8'hF3}, 0, acc);
    check_bytes("single_f3", '{8'hF2, 8'h01, 8'h01, 8'h23});
    idle(1);
    send_play(2'd1, {8'($urandom), 8'h57}, 0, acc);
    check_bytes("single_57", '{8'hF2, 8'h01, 8'h01, 8'h57});
    idle(1);

    // Pair, gap timing, loopback through the receiver decode
    send_play(2'd2, 16'hE1E2, 0, acc);
    check_bytes("pair", '{8'hF2, 8'h02, 8'h02, 8'h11, 8'h12});
    if (rx_log.size() == 5) check("pair_loopback", 32'({to_int(rx_log[3]), to_int(rx_log[4])}), 32'hE1E2);
    if (start_log.size() > 1 && fin_log.size() > 0)
      check("gap_lat", 32'(start_log[1] - fin_log[0]), 32'(GAP + 2));
    idle(1);

    // Illegal play
    send_play(2'd3, 16'h1234, 0, acc);
    check("illegal_err_lat", 32'(err_cyc - acc), 32'd1);
    check("illegal_no_start", 32'(start_log.size()), 32'd0);
    idle(2);

    // Request during WAIT is ignored
    send_play(2'd0, 16'h0000, 3, acc);
    check_bytes("busy", '{8'hF0, 8'hF0, 8'h00});
    idle(30);
    check("busy_no_extra", 32'(start_log.size()), 32'd3);

    // Timeout: UART never finishes
    uart_mute = 1'b1;
    send_play(2'd1, 16'h00F3, 0, acc);
    uart_mute = 1'b0;
    if (start_log.size() > 0) check("timeout_lat", 32'(err_cyc - start_log[0]), 32'(TMO));
    check("timeout_no_done", 32'(done_cyc), 32'hFFFF_FFFF);
    check("timeout_one_start", 32'(start_log.size()), 32'd1);
    check("timeout_ready", 32'(play_ready), 32'd1);
    idle(2);

    // Reset after the second byte's tx_start
    clear_logs();
    run_cycle(1'b0, 1'b1, 2'd2, 16'hE1E2);
    for (int i = 0; i < 100 && start_log.size() < 2; i++) idle(1);
    check("rst_two_starts", 32'(start_log.size()), 32'd2);
    run_cycle(1'b1, 1'b0, 2'd0, 16'h0000);
    check("rst_ready", 32'(play_ready), 32'd1);
    check("rst_tx_start", 32'(tx_start), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'h00);
    check("rst_send_done", 32'(send_done), 32'd0);
    check("rst_send_err", 32'(send_err), 32'd0);
    idle(40);
    check("rst_no_more_start", 32'(start_log.size()), 32'd2);
    send_play(2'd1, 16'hAAF3, 0, acc);
    check_bytes("after_rst", '{8'hF2, 8'h01, 8'h01, 8'h23});
    idle(1);

    // Randomized traffic, checked cycle by cycle against the model
    for (int i = 0; i < 1500; i++) begin
      run_cycle($urandom_range(0, 399) == 0, $urandom_range(0, 5) == 0,
                2'($urandom), 16'($urandom));
    end
    idle(150);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/poker_frame_tx.md
Name: poker_frame_tx

Overview:
- Transmit-side framer for the card-game serial link: turns a local play decision (pass, single card or pair) into a byte frame and hands it byte by byte to the UART transmitter.
- Frames are built so the peer's card receiver decodes them unchanged.
- Sits between the game logic, which supplies cards in internal rank encoding, and the UART TX core.

Parameters:
- GAP_CYCLES, 16: idle sys_clk cycles inserted after each byte completes and before the next tx_start; minimum 1.
- TX_TIMEOUT, 2_000_000: maximum sys_clk cycles to wait for txd_finish_pos after a tx_start before the frame is aborted.

Ports:
- sys_clk  in  1  system clock
- sys_rst  in  1  synchronous active-high reset
- play_req  in  1  one-cycle request to send a play; sampled only when play_ready=1
- play_cnt  in  2  0=pass, 1=single, 2=pair, 3=illegal
- play_cards  in  16  internal-encoded cards; single uses [7:0]; pair sends [15:8] first, then [7:0]
- play_ready  out  1  high in IDLE only
- tx_data  out  8  byte presented to UART TX; stable from tx_start until txd_finish_pos
- tx_start  out  1  one-cycle pulse that launches tx_data
- txd_finish_pos  in  1  one-cycle pulse from UART TX when the byte has been shifted out
- send_done  out  1  one-cycle pulse after the last byte of a frame completes
- send_err  out  1  one-cycle pulse on illegal play_cnt or TX timeout

Behaviour:
- Reset (synchronous, sys_rst=1 at a sys_clk edge): state=IDLE, tx_data=8'h00, tx_start=0, send_done=0, send_err=0, play_ready=1, all counters and frame registers 0. Reset mid-frame aborts the frame immediately. No further tx_start is issued for that frame.
- Frame formats:
  - pass: F0 F0 00
  - single: F2 01 01 c
  - pair: F2 02 02 c1 c2
- Card conversion, per byte, on the upper nibble: F -> 2 and E -> 1; any other nibble is passed unchanged. The lower nibble (suit) is always passed unchanged.
  - Example: internal 8'hF3 is sent as 8'h23; 8'hE0 is sent as 8'h10.
- Frame length is 3, 4 or 5 bytes. Bytes are held in a 5-entry frame buffer loaded in the accept cycle. A 3-bit byte index drives transmission.
- States:
  - IDLE: play_ready=1. When play_req=1:
    - play_cnt=3: stay in IDLE and pulse send_err next cycle.
    - otherwise: latch the frame buffer and length, index=0, go to START.
    - play_req while not in IDLE is ignored. It is neither queued nor flagged.
  - START: tx_data=buf[index], tx_start=1 for exactly this one cycle, clear the timeout counter, go to WAIT.
  - WAIT: count cycles.
    - On txd_finish_pos: if index==len-1, go to DONE; otherwise index+1 and go to GAP.
    - If the count reaches TX_TIMEOUT-1 without txd_finish_pos: pulse send_err and go to IDLE.
  - GAP: wait GAP_CYCLES cycles, then go to START.
  - DONE: pulse send_done for one cycle, go to IDLE.
- txd_finish_pos outside WAIT is ignored.
- If txd_finish_pos and the timeout expire in the same cycle, the finish wins.
- Latency: the first tx_start occurs 2 cycles after the accepted play_req (accept cycle, then the START cycle). send_done occurs 1 cycle after the final txd_finish_pos. play_ready returns high the cycle after that.
- Input stability: play_cards and play_cnt are captured at accept. Later changes do not affect the frame in flight.

Decomposition:
- Shared package poker_pkg holds:
  - header constants HDR_PLAY=8'hF2, HDR_PASS=8'hF0, TYPE_SINGLE=8'h01, TYPE_PAIR=8'h02
  - rank aliases RANK_2_INT=4'hF, RANK_A_INT=4'hE, RANK_2_WIRE=4'h2, RANK_A_WIRE=4'h1
  - play_cnt codes
  - state encoding
- These same constants are used by the receive path.
- One natural sub-module: poker_card_encode, a combinational internal-to-wire byte converter, instantiated twice (once per card lane).

Test Plan:
- Pass: play_req with play_cnt=0 -> tx_data sequence F0,F0,00. Exactly 3 tx_start pulses. send_done once, one cycle after the 3rd finish.
- Single with conversion: play_cnt=1, play_cards[7:0]=8'hF3 -> F2,01,01,23. A second run with 8'h57 -> F2,01,01,57.
- Pair: play_cnt=2, play_cards=16'hE1_E2 -> F2,02,02,11,12 in that order. Loop the frame back into the receiver model and check that its pair output equals 16'hE1E2.
- Illegal and busy requests: play_cnt=3 -> send_err pulse, no tx_start. play_req issued during WAIT -> ignored; only the original frame is sent.
- Timeout: never assert txd_finish_pos, with TX_TIMEOUT=100 -> send_err 100 cycles after tx_start, return to IDLE, no send_done.
- Reset mid-frame: assert sys_rst after the 2nd byte's tx_start -> all outputs return to reset values next cycle, no further tx_start. A fresh single play then sends a correct 4-byte frame.
